// File: rtl/word_packer.sv
// Packs up to four upstream words into one lane-masked group and holds it until
// downstream takes it. A flush closes a partial group early.
module word_packer #(
  parameter int K_DWIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic [K_DWIDTH-1:0]      i_in_word,
  input  logic                     i_flush,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [3:0]               o_data,
  output logic [3:0][K_DWIDTH-1:0] o_mem
);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] cnt;
  logic       accept;

  assign accept = i_in_valid && (state == FILL);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= FILL;
    else          state <= state_nxt;
  end

  // A flush on an empty group with no word arriving would emit nothing, so it is dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      FILL: begin
        if (accept && (cnt == 2'd3))
          state_nxt = HOLD;
        else if (i_flush && ((o_data != 4'd0) || accept))
          state_nxt = HOLD;
      end
      HOLD: begin
        if (i_out_ready) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  always_comb begin
    o_in_ready  = (state == FILL);
    o_out_valid = (state == HOLD);
  end

  // Lanes are cleared when a group leaves so unwritten lanes read back as zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt    <= 2'd0;
      o_data <= 4'd0;
      o_mem  <= '0;
    end else if (accept) begin
      o_mem[cnt]  <= i_in_word;
      o_data[cnt] <= 1'b1;
      cnt         <= cnt + 2'd1;
    end else if ((state == HOLD) && i_out_ready) begin
      cnt    <= 2'd0;
      o_data <= 4'd0;
      o_mem  <= '0;
    end
  end

endmodule

// File: doc/word_packer.md
WORD_PACKER -- requirements
Module: word_packer

Interface
REQ-001 SHALL have parameter K_DWIDTH, default 8, giving the width of one data word; legal range is 1 to 64.
REQ-002 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port i_in_valid, input, 1 bit: upstream word valid.
REQ-005 SHALL have port o_in_ready, output, 1 bit: packer can accept a word.
REQ-006 SHALL have port i_in_word, input, K_DWIDTH bits: upstream data word.
REQ-007 SHALL have port i_flush, input, 1 bit: close and emit a partially filled group.
REQ-008 SHALL have port o_out_valid, output, 1 bit: group on o_mem/o_data is valid.
REQ-009 SHALL have port i_out_ready, input, 1 bit: downstream consumes the group.
REQ-010 SHALL have port o_data, output, 4 bits: lane-valid mask; bit n set means lane n of o_mem holds a word.
REQ-011 SHALL have port o_mem, output, packed [3:0][K_DWIDTH-1:0]: four-lane word group; lane n is o_mem[n].

Function
REQ-012 SHALL implement a two-state FSM: FILL (accepting words) and HOLD (presenting a group).
REQ-013 SHALL keep a 2-bit lane counter cnt, giving the next lane to write; it is meaningful only in FILL.
REQ-014 SHALL drive o_in_ready = 1 in FILL and 0 in HOLD, decoded from the state register only, with no combinational path from any input.
REQ-015 SHALL define an accept as i_in_valid && o_in_ready at a rising edge; on an accept it SHALL write i_in_word to o_mem[cnt], set o_data[cnt], and increment cnt.
REQ-016 SHALL transition FILL->HOLD on the edge of an accept with cnt==3; cnt SHALL wrap to 0 and o_out_valid SHALL be 1 in the following cycle.
REQ-017 SHALL transition FILL->HOLD on i_flush=1 in FILL when at least one lane is written (o_data != 0) or an accept occurs in the same cycle.
REQ-018 SHALL, on i_flush coincident with an accept, store the accepted word first; the emitted group includes it.
REQ-019 SHALL ignore i_flush in FILL when o_data==0 and no accept occurs: no state change and no empty group is emitted.
REQ-020 SHALL ignore i_flush while in HOLD.
REQ-021 SHALL drive o_out_valid = 1 exactly when in HOLD; o_mem and o_data SHALL be stable while o_out_valid=1 and i_out_ready=0.
REQ-022 SHALL transition HOLD->FILL on i_out_ready=1 in HOLD; on that edge it SHALL clear o_data and o_mem to 0 and set cnt to 0.
REQ-023 SHALL keep unwritten lanes of o_mem at 0 in every emitted group.
REQ-024 SHALL give a latency of 1 cycle from the accepting edge of the last word (or the flush edge) to o_out_valid=1.
REQ-025 SHALL sustain a throughput of 4 words per 5 cycles at most, with no accept in any HOLD cycle.
REQ-026 SHALL not depend on words or handshakes other than accepts: i_in_word is don't-care when i_in_valid=0, and i_out_ready is don't-care in FILL.

Reset
REQ-027 SHALL, while i_rst_n=0, immediately force state=FILL, cnt=0, o_data=0, o_mem=0, o_out_valid=0 and o_in_ready=1.
REQ-028 SHALL discard any partial or held group on reset asserted mid-operation, without emitting it.
REQ-029 SHALL accept a word on the first rising edge after i_rst_n deasserts.

Verification (K_DWIDTH=8)
REQ-030 SHALL cover four back-to-back words 0x11,0x22,0x33,0x44 -> next cycle o_out_valid=1, o_data=4'b1111, o_mem={0x44,0x33,0x22,0x11}, o_in_ready=0.
REQ-031 SHALL cover words 0xA1 and 0xB2 followed by a lone i_flush -> o_data=4'b0011, o_mem={0x00,0x00,0xB2,0xA1}.
REQ-032 SHALL cover a third word 0xC3 presented with i_flush in the same cycle -> o_data=4'b0111, lane2=0xC3.
REQ-033 SHALL cover i_flush with an empty group -> o_out_valid stays 0 and the state stays FILL; i_flush during HOLD -> no effect.
REQ-034 SHALL cover i_out_ready held 0 for 10 cycles in HOLD -> o_mem/o_data unchanged and o_in_ready=0; then i_out_ready=1 -> next cycle FILL with o_data=0.
REQ-035 SHALL cover i_rst_n pulsed low after two accepted words -> outputs cleared asynchronously, no group emitted, and the next four words form a clean group.
